// File: rtl/rf_pkg.sv
// Shared defaults and per-entry scoreboard update rule for the register file.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREAD  = 2;

    typedef struct packed {
        logic nxt;
        logic inc;
        logic dec;
    } busy_upd_t;

    // Set has priority over clear, so an issue that re-targets a register being
    // written back in the same cycle keeps it pending. inc/dec are the change in
    // population, which keeps the pending counter equal to the number of set bits.
    function automatic busy_upd_t busy_next(input logic cur, input logic set, input logic clr);
        busy_upd_t u;
        u.nxt = set | (cur & ~clr);
        u.inc = u.nxt & ~cur;
        u.dec = cur & ~u.nxt;
        return u;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy vector, pending count, per-port busy and issue stall.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic                    issue_en,
    input  logic                    issue_dst_en,
    input  logic [ADDR_W-1:0]       issue_dst,
    output logic [NREAD-1:0]        rd_busy,
    output logic                    stall,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] inc_vec;
    logic [DEPTH-1:0] dec_vec;
    logic             waw;
    logic             accept;
    logic             set_en;
    logic             clr_en;
    busy_upd_t        upd;

    // A same-cycle writeback hides the pending mark so decode need not wait a cycle.
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            rd_busy[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]]
                         && !(wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]));
        end
    end

    assign waw    = issue_dst_en && busy[issue_dst] && !(wr_en && (wr_addr == issue_dst));
    assign stall  = issue_en && ((|rd_busy) || waw);
    assign accept = issue_en && !stall;
    assign set_en = accept && issue_dst_en && (issue_dst != '0);
    assign clr_en = wr_en && (wr_addr != '0);

    always_comb begin
        busy_nxt = '0;
        inc_vec  = '0;
        dec_vec  = '0;
        upd      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            upd = busy_next(busy[i],
                            set_en && (issue_dst == ADDR_W'(i)),
                            clr_en && (wr_addr == ADDR_W'(i)));
            busy_nxt[i] = upd.nxt;
            inc_vec[i]  = upd.inc;
            dec_vec[i]  = upd.dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + CNT_W'(|inc_vec) - CNT_W'(|dec_vec);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-through bypass; r0 reads as zero.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    issue_en,
    input  logic                    issue_dst_en,
    input  logic [ADDR_W-1:0]       issue_dst,
    output logic                    stall,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] = (addr == '0)                   ? '0      :
                                             (wr_en && (wr_addr == addr)) ? wr_data :
                                                                            mem[addr];
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .issue_en     (issue_en),
        .issue_dst_en (issue_dst_en),
        .issue_dst    (issue_dst),
        .rd_busy      (rd_busy),
        .stall        (stall),
        .busy_cnt     (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized checks of reg_file_sb against a register/pending-set model.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    issue_en;
    logic                    issue_dst_en;
    logic [ADDR_W-1:0]       issue_dst;
    logic                    stall;
    logic [ADDR_W:0]         busy_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_busy [DEPTH];

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .issue_en     (issue_en),
        .issue_dst_en (issue_dst_en),
        .issue_dst    (issue_dst),
        .stall        (stall),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit wb_hits(input logic [ADDR_W-1:0] a);
        return wr_en && (wr_addr == a);
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_hits(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_rbusy(input logic [ADDR_W-1:0] a);
        return (a != 0) && m_busy[a] && !wb_hits(a);
    endfunction

    function automatic bit exp_stall();
        bit any = 1'b0;
        for (int p = 0; p < NREAD; p++) any |= exp_rbusy(rd_addr[p*ADDR_W +: ADDR_W]);
        if (issue_dst_en && m_busy[issue_dst] && !wb_hits(issue_dst)) any = 1'b1;
        return issue_en && any;
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Applied at the clock edge with the inputs that were present before it.
    task automatic model_update();
        bit acc;
        acc = issue_en && !exp_stall();
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (acc && issue_dst_en && issue_dst != 0) m_busy[issue_dst] = 1'b1;
    endtask

    task automatic check_now(input string tag);
        logic [NREAD*DATA_W-1:0] e_rd;
        logic [NREAD-1:0]        e_rb;
        @(negedge clk);
        for (int p = 0; p < NREAD; p++) begin
            e_rd[p*DATA_W +: DATA_W] = exp_rd(rd_addr[p*ADDR_W +: ADDR_W]);
            e_rb[p]                  = exp_rbusy(rd_addr[p*ADDR_W +: ADDR_W]);
        end
        chk({tag, "_rd_data"}, 64'(rd_data), 64'(e_rd));
        chk({tag, "_rd_busy"}, 64'(rd_busy), 64'(e_rb));
        chk({tag, "_stall"}, 64'(stall), 64'(exp_stall()));
        chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(exp_cnt()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int a0, input int a1, input bit we, input int wa,
                         input logic [DATA_W-1:0] wd, input bit ie, input bit de, input int dst);
        rd_addr      = {ADDR_W'(a1), ADDR_W'(a0)};
        wr_en        = we;
        wr_addr      = ADDR_W'(wa);
        wr_data      = wd;
        issue_en     = ie;
        issue_dst_en = de;
        issue_dst    = ADDR_W'(dst);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // all addresses read zero after reset
        for (int a = 0; a < DEPTH; a++) begin
            drive(a, DEPTH - 1 - a, 0, 0, '0, 1, 0, 0);
            check_now("rst_read");
            tick();
        end

        // bypass, then array, then r0 discard
        drive(5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        check_now("bypass_r5");
        chk("bypass_r5_const", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);
        tick();
        drive(5, 5, 0, 0, '0, 0, 0, 0);
        check_now("array_r5");
        chk("array_r5_const", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);
        tick();
        drive(0, 0, 1, 0, 32'h1234, 0, 0, 0);
        check_now("wr_r0_bypass");
        tick();
        drive(0, 5, 0, 0, '0, 0, 0, 0);
        check_now("wr_r0_array");
        chk("wr_r0_const", 64'(rd_data), 64'hDEADBEEF_00000000);
        tick();

        // RAW stall on r7, cleared by same-cycle writeback
        drive(0, 0, 0, 0, '0, 1, 1, 7);
        check_now("issue_r7");
        tick();
        drive(7, 0, 0, 0, '0, 1, 0, 0);
        check_now("raw_r7");
        chk("raw_r7_stall", 64'(stall), 64'd1);
        chk("raw_r7_cnt", 64'(busy_cnt), 64'd1);
        tick();
        drive(7, 0, 1, 7, 32'h55, 1, 0, 0);
        check_now("raw_r7_wb");
        chk("raw_r7_wb_stall", 64'(stall), 64'd0);
        chk("raw_r7_wb_data", 64'(rd_data[DATA_W-1:0]), 64'h55);
        tick();
        drive(7, 0, 0, 0, '0, 0, 0, 0);
        check_now("raw_r7_after");
        chk("raw_r7_after_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // set and clear of r9 in one cycle: set wins, data written
        drive(0, 0, 0, 0, '0, 1, 1, 9);
        check_now("issue_r9");
        tick();
        drive(0, 0, 1, 9, 32'hA, 1, 1, 9);
        check_now("setclr_r9");
        chk("setclr_r9_stall", 64'(stall), 64'd0);
        tick();
        drive(9, 0, 0, 0, '0, 0, 0, 0);
        check_now("setclr_r9_after");
        chk("setclr_r9_data", 64'(rd_data[DATA_W-1:0]), 64'hA);
        chk("setclr_r9_cnt", 64'(busy_cnt), 64'd1);
        chk("setclr_r9_busy", 64'(rd_busy), 64'd1);
        tick();

        // WAW on r3
        drive(0, 0, 0, 0, '0, 1, 1, 3);
        check_now("issue_r3");
        tick();
        drive(0, 0, 0, 0, '0, 1, 1, 3);
        check_now("waw_r3");
        chk("waw_r3_stall", 64'(stall), 64'd1);
        tick();
        drive(0, 0, 1, 3, 32'h33, 1, 1, 3);
        check_now("waw_r3_wb");
        chk("waw_r3_wb_stall", 64'(stall), 64'd0);
        tick();
        drive(3, 9, 0, 0, '0, 0, 0, 0);
        check_now("waw_r3_after");
        chk("waw_r3_after_cnt", 64'(busy_cnt), 64'd2);
        tick();

        // drain, then mark r1 r2 r4 and reset between edges
        drive(0, 0, 1, 3, 32'h3, 0, 0, 0);
        check_now("drain_r3");
        tick();
        drive(0, 0, 1, 9, 32'h9, 0, 0, 0);
        check_now("drain_r9");
        tick();
        drive(0, 0, 0, 0, '0, 1, 1, 1);
        check_now("mark_r1");
        tick();
        drive(0, 0, 0, 0, '0, 1, 1, 2);
        check_now("mark_r2");
        tick();
        drive(0, 0, 0, 0, '0, 1, 1, 4);
        check_now("mark_r4");
        tick();
        drive(1, 5, 0, 0, '0, 1, 0, 0);
        check_now("pre_rst");
        chk("pre_rst_cnt", 64'(busy_cnt), 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_busy", 64'(rd_busy), 64'd0);
        chk("mid_rst_data", 64'(rd_data), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic on a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), bit'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom, bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 7));
            check_now("rand");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with write-through bypass and a per-register pending-write scoreboard, for the pipelined CPU datapath. It replaces the fixed 32×32, two-read-port register file. The decode stage reads operands and records destinations at issue. Writeback clears a destination's pending mark on the same port that writes its data. The block raises a stall when an issuing instruction reads a register whose result has not yet returned.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W; register 0 hardwired to zero
- NREAD, 2, number of read ports (1..4)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NREAD*ADDR_W  read addresses, port i in bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port i in bits [i*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port i address pending (after bypass/clear rules)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- issue_en  in  1  decode requests issue of instruction reading all NREAD ports
- issue_dst_en  in  1  issuing instruction has a destination
- issue_dst  in  ADDR_W  destination to mark pending
- stall  out  1  issue refused this cycle
- busy_cnt  out  ADDR_W+1  number of pending registers

## Operation
- Storage: 2**ADDR_W × DATA_W array plus busy vector of 2**ADDR_W bits.
- Write:
  - On posedge with wr_en=1 and wr_addr≠0, store wr_data.
  - The same edge clears busy[wr_addr], unless the set rule below applies.
  - Writes to address 0 are discarded.
- Read (combinational, port i):
  - rd_addr=0 → 0.
  - Else if wr_en and wr_addr==rd_addr → wr_data (bypass).
  - Else → stored value.
- rd_busy[i] = busy[rd_addr_i] AND NOT (wr_en AND wr_addr==rd_addr_i). Always 0 for address 0.
- stall = issue_en AND (OR of rd_busy), OR issue_en AND issue_dst_en AND busy[issue_dst] with no same-cycle writeback to issue_dst (WAW).
- Issue accepted: issue_en=1 and stall=0. On acceptance with issue_dst_en=1 and issue_dst≠0, set busy[issue_dst] at posedge.
- Simultaneous set and clear of the same address (accepted issue plus writeback): set wins, busy stays 1, data is written.
- Stalled issue changes no state; decode holds inputs and retries.
- Writeback to a non-busy register is legal: data is written, busy is unchanged.
- busy_cnt is a registered counter, updated each edge by +1 on set, −1 on clear, 0 net on set and clear of the same address. It never underflows, because a clear of a non-busy bit does not decrement.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all registers 0, busy all 0, busy_cnt 0.
  - Combinational outputs then follow: rd_data 0 unless bypassed, rd_busy 0, stall 0.
- Read latency 0 cycles. Written value visible through the array from the cycle after the edge and through bypass in the same cycle.
- Scoreboard set visible from the cycle after acceptance. A clear is visible in the same cycle via the rd_busy/stall bypass terms.
- Reset mid-operation discards all pending marks. The pipeline is flushed externally.

## Structure
- Shared package rf_pkg: default DATA_W/ADDR_W/NREAD constants, and the function computing the next busy vector and count delta.
- Natural sub-module: rf_scoreboard (busy vector, busy_cnt, stall/rd_busy logic). The top holds the data array and bypass muxing.

## Test plan
- Reset then read all ports at addresses 0..31 → all rd_data 0, busy_cnt 0, stall 0.
- Write 0xDEADBEEF to r5, read r5 on both ports in the same cycle → bypass returns 0xDEADBEEF; next cycle array returns it. Write 0x1234 to r0 → reads 0.
- Issue dst r7, next cycle issue_en reading r7 → stall=1, rd_busy=1, busy_cnt 1. Writeback r7=0x55 while issue held → stall=0, rd_data 0x55, busy_cnt 0 next cycle.
- Same cycle: accepted issue dst r9 and writeback r9=0xA → r9 holds 0xA, busy[9] stays 1, busy_cnt unchanged at 1.
- Issue dst r3 while r3 busy → stall=1 (WAW), busy_cnt unchanged; repeat with a same-cycle writeback to r3 → accepted, busy stays 1.
- Mark r1, r2, r4 busy (busy_cnt 3), assert rst mid-cycle → busy_cnt 0 and all registers 0 immediately, before the next clk edge.
